pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 117 +++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//   Two-entry pipeline register (main + skid) for a valid/ready interface.
//   out_data/out_valid come straight from the main register. in_ready is a
//   registered function of occupancy, so it has no combinational path from
//   out_ready or in_valid. That keeps the ready path short across pipeline
//   stages. The block still gives one transfer per cycle in both directions
//   when neither side stalls.
//
// Parameters
//   DW          payload width
//   RESET_VALUE value loaded into both data registers on reset
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   flush      synchronous discard of all held entries
//   in_valid   upstream offers in_data
//   in_ready   block can accept this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid entry
//   out_ready  downstream accepts this cycle
//   out_data   downstream payload
//   count      number of held entries (0..2)
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int              DW          = 32,
    parameter logic [DW-1:0]   RESET_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    count
);

    // Occupancy state; skid is only ever valid in FULL, so the invariant
    // "skid valid implies main valid" holds by construction.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;

    logic main_vld, skid_vld;
    logic in_xfer, out_xfer;

    assign main_vld  = (state_q != EMPTY);
    assign skid_vld  = (state_q == FULL);

    assign in_ready  = rst && !skid_vld;
    assign out_valid = main_vld;
    assign out_data  = main_q;
    assign count     = {1'b0, main_vld} + {1'b0, skid_vld};

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = main_vld && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_data;
                end else if (in_xfer) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops everything but leaves the data registers untouched.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VALUE;
            skid_q  <= RESET_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
